// File: rtl/avg_pkg.sv
// avg_pkg: shared constants and elaboration-time helpers for the pipelined averager.
package avg_pkg;
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_NUM_CH       = 8;
    localparam int DEF_MAX_ACC_LOG2 = 4;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int levels(input int num_ch);
        return clog2(num_ch);
    endfunction
    function automatic int acc_width(input int data_w, input int num_ch, input int max_acc_log2);
        return data_w + levels(num_ch) + max_acc_log2;
    endfunction
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction
    // Bit offset of tree level lvl inside one flat vector holding every level back to back.
    function automatic int lvl_off(input int lvl, input int data_w, input int num_ch);
        int o = 0;
        for (int k = 0; k < lvl; k++) o += (num_ch >> k) * (data_w + k);
        return o;
    endfunction
    typedef logic [acc_width(DEF_DATA_W, DEF_NUM_CH, DEF_MAX_ACC_LOG2)-1:0] acc_t;
endpackage

// File: rtl/avg_add_stage.sv
// avg_add_stage: one registered adder-tree level summing adjacent lane pairs.
module avg_add_stage
    import avg_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int PAIRS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      adv,
    input  logic                      in_valid,
    input  logic [2*PAIRS*IN_W-1:0]   in_data,
    output logic                      out_valid,
    output logic [PAIRS*(IN_W+1)-1:0] out_data
);
    logic [PAIRS*(IN_W+1)-1:0] sum;
    for (genvar i = 0; i < PAIRS; i++) begin : g_pair
        assign sum[lane_lo(i, IN_W+1) +: IN_W+1] = (IN_W+1)'(in_data[lane_lo(2*i, IN_W) +: IN_W])
                                                 + (IN_W+1)'(in_data[lane_lo(2*i+1, IN_W) +: IN_W]);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_data  <= sum;
        end
endmodule

// File: rtl/pipelined_avg.sv
// pipelined_avg: valid/ready averager of NUM_CH lanes over 2^acc_log2 beats.
// Define PIPELINED_AVG_ROUND_EN for round-half-up results instead of floor.
module pipelined_avg
    import avg_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int NUM_CH       = 8,
    parameter int MAX_ACC_LOG2 = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_CH*DATA_W-1:0]         in_data,
    input  logic [clog2(MAX_ACC_LOG2+1)-1:0] acc_log2,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_avg,
    output logic                             busy
);
    localparam int L  = levels(NUM_CH);
    localparam int AW = acc_width(DATA_W, NUM_CH, MAX_ACC_LOG2);
    localparam int CW = clog2(MAX_ACC_LOG2 + 1);
    localparam int NW = MAX_ACC_LOG2 + 1;
    localparam int TW = DATA_W + L;
    logic                                    adv, v0;
    logic [NUM_CH*DATA_W-1:0]                d0;
    logic [L:0]                              v;
    logic [lvl_off(L+1, DATA_W, NUM_CH)-1:0] lvl;
    logic [TW-1:0]                           tsum;
    logic [AW-1:0]                           acc, total;
    logic [NW-1:0]                           cnt, cnt_n;
    logic [CW-1:0]                           win, lg, eff;
    logic [DATA_W-1:0]                       avg_n;
    logic                                    first, last;
    assign adv      = !out_valid || out_ready;
    assign in_ready = rst && adv;
    assign busy     = |v || cnt != '0 || out_valid;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            v0 <= 1'b0;
            d0 <= '0;
        end else if (adv) begin
            v0 <= in_valid;
            d0 <= in_data;
        end
    assign v[0] = v0;
    assign lvl[NUM_CH*DATA_W-1:0] = d0;
    for (genvar k = 1; k <= L; k++) begin : g_lvl
        avg_add_stage #(.IN_W(DATA_W + k - 1), .PAIRS(NUM_CH >> k)) u_stage (
            .clk,
            .rst,
            .adv,
            .in_valid (v[k-1]),
            .in_data  (lvl[lvl_off(k-1, DATA_W, NUM_CH) +: (NUM_CH >> (k-1)) * (DATA_W + k - 1)]),
            .out_valid(v[k]),
            .out_data (lvl[lvl_off(k, DATA_W, NUM_CH) +: (NUM_CH >> k) * (DATA_W + k)])
        );
    end
    assign tsum = lvl[lvl_off(L, DATA_W, NUM_CH) +: TW];
    // Window length is taken from acc_log2 only when a tree result opens a new window.
    always_comb begin
        eff   = acc_log2 > CW'(MAX_ACC_LOG2) ? CW'(MAX_ACC_LOG2) : acc_log2;
        first = cnt == '0;
        lg    = first ? eff : win;
        cnt_n = first ? NW'(1) : cnt + NW'(1);
        last  = cnt_n == (NW'(1) << lg);
        total = (first ? '0 : acc) + AW'(tsum);
    end
`ifdef PIPELINED_AVG_ROUND_EN
    assign avg_n = DATA_W'(((AW+1)'(total) + ((AW+1)'(1) << (L + lg - 1))) >> (L + lg));
`else
    assign avg_n = DATA_W'(total >> (L + lg));
`endif
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            acc       <= '0;
            cnt       <= '0;
            win       <= '0;
            out_avg   <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= v[L] && last;
            if (v[L] && last) begin
                out_avg <= avg_n;
                cnt     <= '0;
            end else if (v[L]) begin
                acc <= total;
                cnt <= cnt_n;
                win <= lg;
            end
        end
endmodule

// File: tb/tb_pipelined_avg.sv
// tb_pipelined_avg: directed stimulus against a window-averaging reference model.
module tb_pipelined_avg;
    logic         clk = 0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [2:0]   acc_log2;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_avg;
    logic         busy;

    int     n_cmp = 0, n_bad = 0, n_out = 0, base;
    longint last_out = 0;
    longint exp_q[$];
    longint m_sum = 0;
    int     m_cnt = 0, m_win = 0;
    bit     prev_stall = 0;
    logic [15:0] prev_avg = 0;

    pipelined_avg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .acc_log2(acc_log2), .out_valid(out_valid), .out_ready(out_ready), .out_avg(out_avg), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic longint lane_sum(input logic [127:0] d);
        longint s = 0;
        for (int j = 0; j < 8; j++) s += longint'(d[j*16 +: 16]);
        return s;
    endfunction

    function automatic longint avg_of(input longint s, input int sh);
`ifdef PIPELINED_AVG_ROUND_EN
        return (s + (longint'(1) << (sh - 1))) >> sh;
`else
        return s >> sh;
`endif
    endfunction

    function automatic logic [127:0] fill(input logic [15:0] x);
        return {8{x}};
    endfunction

    // Reference model: windows of 2^n beats (n clamped to 4, fixed when a window opens).
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_sum = 0;
            m_cnt = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_avg", out_avg, prev_avg);
            end
            check("in_ready", in_ready, !out_valid || out_ready);
            if (in_valid && in_ready) begin
                if (m_cnt == 0) m_win = acc_log2 > 3'd4 ? 4 : int'(acc_log2);
                m_sum += lane_sum(in_data);
                m_cnt++;
                if (m_cnt == (1 << m_win)) begin
                    exp_q.push_back(avg_of(m_sum, 3 + m_win));
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                last_out = out_avg;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_out: got %0d, required no result", out_avg);
                end else check("out_avg", out_avg, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_avg = out_avg;
        end
    end

    task automatic step(output bit took);
        @(negedge clk);
        took = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        bit took = 0;
        in_valid = 1;
        in_data = d;
        for (int i = 0; i < 40 && !took; i++) step(took);
        if (!took) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready got 0, required 1 within 40 cycles");
        end
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        bit t;
        for (int i = 0; i < n; i++) step(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        logic [127:0] d;
        bit t;
        rst = 1; in_valid = 0; in_data = 0; acc_log2 = 0; out_ready = 1;
        #1 rst = 0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_avg", out_avg, 0);
        rst = 1;
        idle(2);

        // Basic: lanes 1..8, single-beat window, 4-cycle latency
        for (int j = 0; j < 8; j++) d[j*16 +: 16] = 16'(j + 1);
        send(d);
        c = 0;
        for (int i = 1; i <= 20 && c == 0; i++) begin
            @(posedge clk); #1;
            if (out_valid) c = i;
        end
        check("latency", c, 4);
        @(negedge clk); #1;
`ifdef PIPELINED_AVG_ROUND_EN
        check("basic_avg", last_out, 5);
`else
        check("basic_avg", last_out, 4);
`endif
        idle(4);

        // Accumulation: 16 full-scale beats give one full-scale result
        acc_log2 = 4;
        base = n_out;
        for (int b = 0; b < 16; b++) send(fill(16'hFFFF));
        idle(10);
        check("acc_count", n_out - base, 1);
        check("acc_avg", last_out, 16'hFFFF);

        // Backpressure: continuous stream, out_ready low for 5 cycles
        acc_log2 = 0;
        base = n_out;
        c = 0;
        for (int cy = 0; cy < 60 && c < 12; cy++) begin
            for (int j = 0; j < 8; j++) d[j*16 +: 16] = 16'(c * 37 + j * 1000 + 5);
            in_valid = 1;
            in_data = d;
            out_ready = !(cy >= 6 && cy < 11);
            #1;
            if (cy >= 6 && cy < 11) check("bp_in_ready", in_ready, 0);
            step(t);
            if (t) c++;
        end
        in_valid = 0;
        out_ready = 1;
        idle(10);
        check("bp_count", n_out - base, 12);
        check("bp_queue_empty", exp_q.size(), 0);

        // Window latch: length 2 fixed at window start despite acc_log2 change
        acc_log2 = 1;
        base = n_out;
        send(fill(16'd10));
        idle(6);
        check("latch_busy", busy, 1);
        acc_log2 = 3;
        send(fill(16'd20));
        idle(8);
        check("latch_count", n_out - base, 1);
        check("latch_avg", last_out, 15);
        base = n_out;
        for (int b = 0; b < 7; b++) send(fill(16'(b + 1)));
        idle(8);
        check("win8_partial", n_out - base, 0);
        send(fill(16'd8));
        idle(8);
        check("win8_count", n_out - base, 1);
`ifdef PIPELINED_AVG_ROUND_EN
        check("win8_avg", last_out, 5);
`else
        check("win8_avg", last_out, 4);
`endif

        // Async reset with a stalled result and beats in flight
        acc_log2 = 2;
        out_ready = 0;
        for (int b = 0; b < 6; b++) send(b < 4 ? fill(16'd40) : fill(16'd1000));
        for (int i = 0; i < 20 && !out_valid; i++) step(t);
        check("pre_rst_valid", out_valid, 1);
        rst = 0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_out_avg", out_avg, 0);
        idle(2);
        rst = 1;
        out_ready = 1;
        base = n_out;
        for (int b = 0; b < 4; b++) send(fill(16'd3));
        idle(10);
        check("post_rst_count", n_out - base, 1);
        check("post_rst_avg", last_out, 3);

        // Clamp: acc_log2=7 behaves as 16-beat windows
        acc_log2 = 7;
        base = n_out;
        for (int b = 0; b < 15; b++) send(fill(16'(b)));
        idle(8);
        check("clamp_partial", n_out - base, 0);
        send(fill(16'd15));
        idle(8);
        check("clamp_count", n_out - base, 1);
`ifdef PIPELINED_AVG_ROUND_EN
        check("clamp_avg", last_out, 8);
`else
        check("clamp_avg", last_out, 7);
`endif
        check("idle_busy", busy, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
